// File: rtl/sdrc_bist_pkg.sv
// Shared types and LFSR helper for the sdrc_core traffic generator/checker.
package sdrc_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_NEXT,
        ST_DONE
    } state_e;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1 (tap n lands on bit n-1).
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/sdrc_bist_lfsr.sv
// 32-bit Galois LFSR with synchronous reload; load+step reloads and advances once.
module sdrc_bist_lfsr
    import sdrc_bist_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1234_5678
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] value_q;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= SEED;
        end else if (load) begin
            value_q <= step ? lfsr_next(seed) : seed;
        end else if (step) begin
            value_q <= lfsr_next(value_q);
        end
    end

    assign value = value_q;

endmodule

// File: rtl/sdrc_bist_gen.sv
// Write/read-back traffic generator and checker driving the sdrc_core application port.
module sdrc_bist_gen
    import sdrc_bist_pkg::*;
#(
    parameter int          DW         = 32,
    parameter int          NUM_BURSTS = 20,
    parameter logic [29:0] ADDR_MASK  = 30'h000F_FFFF,
    parameter logic [5:0]  LEN_MASK   = 6'h3F,
    parameter logic [31:0] SEED       = 32'h1234_5678,
    parameter int          TIMEOUT    = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            sdr_init_done,
    output logic            app_req,
    output logic [29:0]     app_req_addr,
    output logic [8:0]      app_req_len,
    output logic            app_req_wr_n,
    input  logic            app_req_ack,
    output logic [DW-1:0]   app_wr_data,
    output logic [DW/8-1:0] app_wr_en_n,
    input  logic            app_wr_next_req,
    input  logic            app_rd_valid,
    input  logic [DW-1:0]   app_rd_data,
    input  logic            app_last_rd,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_cnt,
    output logic            timeout_err
);

    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [15:0]    NB      = 16'(NUM_BURSTS);

    state_e            state_q;
    logic [29:0]       addr_q;
    logic [8:0]        len_q, beat_cnt_q, wr_cnt_d;
    logic [31:0]       burst_seed_q;
    logic [15:0]       burst_idx_q, err_cnt_q, err_cnt_d;
    logic [WDW-1:0]    wdog_q, wdog_d;
    logic              app_req_q, wr_n_q, busy_q, done_q, tmo_q;
    logic [DW/8-1:0]   wr_en_n_q;

    logic [31:0] plfsr_val, dlfsr_val, gen_src, d_seed;
    logic [29:0] gen_addr;
    logic [8:0]  gen_len;
    logic        is_start, wr_state, run_state, wr_beat, rd_beat, beat_last;
    logic        spur_rd, spur_wr, rd_mismatch, last_err, any_evt, wd_fire;
    logic        enter_rd, last_burst, p_step, d_load, d_step;
    logic [2:0]  err_inc;
    logic [16:0] err_sum;

    assign is_start  = start && sdr_init_done && (state_q == ST_IDLE || state_q == ST_DONE);
    assign wr_state  = (state_q == ST_WR_REQ) || (state_q == ST_WR_DATA);
    assign run_state = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // A new run takes its first burst straight from SEED, as the LFSR is reloaded that same edge.
    assign gen_src  = is_start ? SEED : plfsr_val;
    assign gen_addr = gen_src[29:0] & ADDR_MASK;
    assign gen_len  = {3'b000, gen_src[31:26] & LEN_MASK} + 9'd1;

    assign wr_beat     = app_wr_next_req && wr_state;
    assign rd_beat     = app_rd_valid && (state_q == ST_RD_DATA);
    assign wr_cnt_d    = beat_cnt_q + {8'd0, wr_beat};
    assign beat_last   = (beat_cnt_q + 9'd1) == len_q;
    assign enter_rd    = (state_q == ST_WR_DATA) && (wr_cnt_d == len_q);
    assign last_burst  = (burst_idx_q + 16'd1) == NB;

    assign spur_rd     = app_rd_valid && (state_q != ST_RD_DATA);
    assign spur_wr     = app_wr_next_req && !wr_state;
    assign rd_mismatch = rd_beat && (app_rd_data != DW'(dlfsr_val));
    assign last_err    = rd_beat && (app_last_rd != beat_last);
    assign err_inc     = 3'(spur_rd) + 3'(spur_wr) + 3'(rd_mismatch) + 3'(last_err);
    assign err_sum     = {1'b0, err_cnt_q} + 17'(err_inc);
    assign err_cnt_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    assign any_evt = app_req_ack || app_wr_next_req || app_rd_valid;
    assign wd_fire = run_state && !any_evt && (wdog_q == WD_LAST);
    assign wdog_d  = (!run_state || any_evt) ? '0 : wdog_q + 1'b1;

    assign p_step = is_start || (state_q == ST_NEXT && !last_burst);
    assign d_load = is_start || enter_rd;
    assign d_seed = is_start ? SEED : burst_seed_q;
    // Reload wins over the last write beat so the read pass starts from the burst seed.
    assign d_step = (wr_beat || rd_beat) && !d_load;

    sdrc_bist_lfsr #(.SEED(SEED)) u_plfsr (
        .clk   (clk),
        .reset (reset),
        .load  (is_start),
        .step  (p_step),
        .seed  (SEED),
        .value (plfsr_val)
    );

    sdrc_bist_lfsr #(.SEED(SEED)) u_dlfsr (
        .clk   (clk),
        .reset (reset),
        .load  (d_load),
        .step  (d_step),
        .seed  (d_seed),
        .value (dlfsr_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            burst_seed_q <= '0;
            burst_idx_q  <= '0;
            err_cnt_q    <= '0;
            wdog_q       <= '0;
            app_req_q    <= 1'b0;
            wr_n_q       <= 1'b1;
            wr_en_n_q    <= '1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            wdog_q    <= wdog_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (is_start) begin
                        state_q      <= ST_WR_REQ;
                        err_cnt_q    <= '0;
                        done_q       <= 1'b0;
                        tmo_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        burst_idx_q  <= '0;
                        addr_q       <= gen_addr;
                        len_q        <= gen_len;
                        burst_seed_q <= SEED;
                        beat_cnt_q   <= '0;
                        app_req_q    <= 1'b1;
                        wr_n_q       <= 1'b0;
                        wr_en_n_q    <= '0;
                    end
                end
                ST_WR_REQ: begin
                    beat_cnt_q <= wr_cnt_d;
                    if (app_req_ack) begin
                        app_req_q <= 1'b0;
                        state_q   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (enter_rd) begin
                        state_q    <= ST_RD_REQ;
                        wr_en_n_q  <= '1;
                        app_req_q  <= 1'b1;
                        wr_n_q     <= 1'b1;
                        beat_cnt_q <= '0;
                    end else begin
                        beat_cnt_q <= wr_cnt_d;
                    end
                end
                ST_RD_REQ: begin
                    if (app_req_ack) begin
                        app_req_q <= 1'b0;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_beat) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (beat_last) state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    burst_idx_q <= burst_idx_q + 16'd1;
                    if (last_burst) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= ST_WR_REQ;
                        addr_q       <= gen_addr;
                        len_q        <= gen_len;
                        burst_seed_q <= dlfsr_val;
                        beat_cnt_q   <= '0;
                        app_req_q    <= 1'b1;
                        wr_n_q       <= 1'b0;
                        wr_en_n_q    <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (wd_fire) begin
                state_q   <= ST_DONE;
                app_req_q <= 1'b0;
                wr_n_q    <= 1'b1;
                wr_en_n_q <= '1;
                tmo_q     <= 1'b1;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
            end
        end
    end

    assign app_req      = app_req_q;
    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;
    assign app_req_wr_n = wr_n_q;
    assign app_wr_en_n  = wr_en_n_q;
    assign app_wr_data  = wr_en_n_q[0] ? '0 : DW'(dlfsr_val);
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_cnt      = err_cnt_q;
    assign timeout_err  = tmo_q;
    assign pass         = done_q && (err_cnt_q == 16'd0) && !tmo_q;

endmodule
